xfcp_mod_id: RTL and testbench

- XFCP endpoint (responder) on the upstream side of an XFCP switch port; answers ID requests issued by the host through the UART/COBS interface.
- Consumes request packets on up_xfcp_in_* and produces response packets on up_xfcp_out_*.
- Echoes the return path, then emits a fixed identification record from parameters.
- Any request of another type yields a bad-frame-terminated output, which a downstream frame FIFO discards.

---
 rtl/xfcp_mod_id.sv | 167 ++++++++++++++++
 tb/tb_xfcp_mod_id.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xfcp_mod_id.sv
// XFCP ID endpoint: echoes the return path of an ID request and answers
// with a fixed identification record; anything else ends in a bad frame.
module xfcp_mod_id #(
    parameter logic [15:0]  XFCP_ID_TYPE = 16'h0001,
    parameter logic [127:0] XFCP_ID_STR  = {"XFCP Mod ID", 40'h0},
    parameter logic [127:0] XFCP_EXT_ID  = 128'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] up_xfcp_in_tdata,
    input  logic       up_xfcp_in_tvalid,
    output logic       up_xfcp_in_tready,
    input  logic       up_xfcp_in_tlast,
    input  logic       up_xfcp_in_tuser,
    output logic [7:0] up_xfcp_out_tdata,
    output logic       up_xfcp_out_tvalid,
    input  logic       up_xfcp_out_tready,
    output logic       up_xfcp_out_tlast,
    output logic       up_xfcp_out_tuser
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RPATH,
        S_TYPE,
        S_DRAIN,
        S_SEND,
        S_ABORT
    } state_t;

    // Response record, byte 0 in the top bits.
    localparam logic [279:0] ROM = {
        8'hFF, XFCP_ID_TYPE[7:0], XFCP_ID_TYPE[15:8],
        XFCP_ID_STR, XFCP_EXT_ID
    };

    state_t     r_state, w_state_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;
    logic       r_abort, w_abort_nxt;
    logic [7:0] r_tdata, w_tdata_nxt;
    logic       r_tvalid, w_tvalid_nxt;
    logic       r_tlast, w_tlast_nxt;
    logic       r_tuser, w_tuser_nxt;

    logic       w_load;
    logic       w_in_rdy;
    logic       w_in_hs;
    logic [5:0] w_rom_idx;
    logic [7:0] w_rom_byte;

    assign w_load     = !r_tvalid || up_xfcp_out_tready;
    assign w_rom_idx  = 6'd34 - r_cnt;
    assign w_rom_byte = ROM[{w_rom_idx, 3'b000} +: 8];

    always_comb begin
        w_in_rdy = 1'b0;
        unique case (r_state)
            S_IDLE, S_RPATH: w_in_rdy = w_load;
            S_TYPE, S_DRAIN: w_in_rdy = 1'b1;
            default:         w_in_rdy = 1'b0;
        endcase
    end

    assign up_xfcp_in_tready = w_in_rdy && rst_n;
    assign w_in_hs = up_xfcp_in_tready && up_xfcp_in_tvalid;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_abort_nxt  = r_abort;
        w_tdata_nxt  = r_tdata;
        w_tvalid_nxt = r_tvalid;
        w_tlast_nxt  = r_tlast;
        w_tuser_nxt  = r_tuser;
        if (w_load) begin
            w_tvalid_nxt = 1'b0;
        end
        unique case (r_state)
            S_IDLE, S_RPATH: begin
                if (w_in_hs) begin
                    w_tdata_nxt  = up_xfcp_in_tdata;
                    w_tvalid_nxt = 1'b1;
                    if (up_xfcp_in_tlast) begin
                        // Packet ended before a type byte: mark it bad.
                        w_tlast_nxt = 1'b1;
                        w_tuser_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tlast_nxt = 1'b0;
                        w_tuser_nxt = 1'b0;
                        w_state_nxt = (up_xfcp_in_tdata == 8'hFE) ?
                                      S_TYPE : S_RPATH;
                    end
                end
            end
            S_TYPE: begin
                if (w_in_hs) begin
                    w_abort_nxt = (up_xfcp_in_tdata != 8'hFE);
                    if (!up_xfcp_in_tlast) begin
                        w_state_nxt = S_DRAIN;
                    end else if (up_xfcp_in_tdata == 8'hFE &&
                                 !up_xfcp_in_tuser) begin
                        w_state_nxt = S_SEND;
                    end else begin
                        w_state_nxt = S_ABORT;
                    end
                end
            end
            S_DRAIN: begin
                if (w_in_hs && up_xfcp_in_tlast) begin
                    w_state_nxt = (r_abort || up_xfcp_in_tuser) ?
                                  S_ABORT : S_SEND;
                end
            end
            S_SEND: begin
                if (w_load) begin
                    w_tdata_nxt  = w_rom_byte;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = (r_cnt == 6'd34);
                    w_tuser_nxt  = 1'b0;
                    if (r_cnt == 6'd34) begin
                        w_cnt_nxt   = 6'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            S_ABORT: begin
                if (w_load) begin
                    w_tdata_nxt  = 8'h00;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = 1'b1;
                    w_tuser_nxt  = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_abort  <= 1'b0;
            r_tdata  <= 8'h00;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_abort  <= w_abort_nxt;
            r_tdata  <= w_tdata_nxt;
            r_tvalid <= w_tvalid_nxt;
            r_tlast  <= w_tlast_nxt;
            r_tuser  <= w_tuser_nxt;
        end
    end

    assign up_xfcp_out_tdata  = r_tdata;
    assign up_xfcp_out_tvalid = r_tvalid;
    assign up_xfcp_out_tlast  = r_tlast;
    assign up_xfcp_out_tuser  = r_tuser;

endmodule

// File: tb/tb_xfcp_mod_id.sv
// Bench for xfcp_mod_id: directed and random requests against a
// packet-level reference model of the XFCP ID protocol.
module tb_xfcp_mod_id;

    typedef logic [7:0] bq_t[$];
    typedef logic [9:0] oq_t[$];

    localparam logic [15:0] ID_TYPE = 16'h0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_tdata = 8'h00;
    logic       in_tvalid = 1'b0;
    logic       in_tready;
    logic       in_tlast = 1'b0;
    logic       in_tuser = 1'b0;
    logic [7:0] out_tdata;
    logic       out_tvalid;
    logic       out_tready = 1'b1;
    logic       out_tlast;
    logic       out_tuser;

    int  n_total = 0;
    int  n_bad = 0;
    bit  rnd_rdy = 1'b0;
    oq_t mon_q;
    int  stab_err = 0;
    bit  prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;

    xfcp_mod_id dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .up_xfcp_in_tdata   (in_tdata),
        .up_xfcp_in_tvalid  (in_tvalid),
        .up_xfcp_in_tready  (in_tready),
        .up_xfcp_in_tlast   (in_tlast),
        .up_xfcp_in_tuser   (in_tuser),
        .up_xfcp_out_tdata  (out_tdata),
        .up_xfcp_out_tvalid (out_tvalid),
        .up_xfcp_out_tready (out_tready),
        .up_xfcp_out_tlast  (out_tlast),
        .up_xfcp_out_tuser  (out_tuser)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Records accepted beats; a stalled beat must stay put.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall &&
                !(out_tvalid && {out_tlast, out_tuser, out_tdata} == prev_beat))
                stab_err++;
            if (out_tvalid && out_tready)
                mon_q.push_back({out_tlast, out_tuser, out_tdata});
            prev_stall = out_tvalid && !out_tready;
            prev_beat  = {out_tlast, out_tuser, out_tdata};
        end
    end

    function automatic oq_t model(bq_t req, logic b);
        oq_t   o;
        int    m = -1;
        int    n = req.size();
        string s = "XFCP Mod ID";
        for (int i = 0; i < n; i++)
            if (m < 0 && req[i] == 8'hFE) m = i;
        if (m < 0) begin
            for (int i = 0; i < n; i++)
                o.push_back({(i == n - 1), (i == n - 1), req[i]});
            return o;
        end
        for (int i = 0; i <= m; i++) o.push_back({2'b00, req[i]});
        if (m + 1 < n && req[m + 1] == 8'hFE && !b) begin
            o.push_back({2'b00, 8'hFF});
            o.push_back({2'b00, ID_TYPE[7:0]});
            o.push_back({2'b00, ID_TYPE[15:8]});
            for (int k = 0; k < 16; k++)
                o.push_back({2'b00, (k < s.len()) ? s[k] : 8'h00});
            for (int k = 0; k < 16; k++)
                o.push_back({(k == 15), 1'b0, 8'h00});
        end else begin
            o.push_back({2'b11, 8'h00});
        end
        return o;
    endfunction

    task automatic send_bytes(input bq_t req, input logic b, output bit to);
        int w;
        to = 1'b0;
        for (int i = 0; i < req.size(); i++) begin
            in_tdata  = req[i];
            in_tlast  = (i == req.size() - 1);
            in_tuser  = b && in_tlast;
            in_tvalid = 1'b1;
            w = 0;
            @(negedge clk);
            while (!in_tready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) to = 1'b1;
            @(posedge clk);
            #1;
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tuser  = 1'b0;
    endtask

    task automatic run_pkt(input bq_t req, input logic b, input int exp_n,
                           output oq_t obs, output bit to);
        int w = 0;
        bit t1;
        mon_q = {};
        send_bytes(req, b, t1);
        while (mon_q.size() < exp_n && w < 2000) begin
            @(posedge clk);
            w++;
        end
        to = t1 || (w >= 2000);
        repeat (8) @(posedge clk);
        #1;
        obs = mon_q;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_total++;
        if ({out_tvalid, out_tdata, out_tlast, out_tuser} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_out got v=%b d=%h l=%b u=%b want 0",
                     out_tvalid, out_tdata, out_tlast, out_tuser);
        end
        n_total++;
        if (in_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready got %b want 0", in_tready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_id_basic;
        bq_t req = '{8'hFE, 8'hFE};
        oq_t exp = model(req, 1'b0);
        oq_t obs;
        bit  to;
        rnd_rdy = 1'b0;
        run_pkt(req, 1'b0, exp.size(), obs, to);
        n_total++;
        if (to || obs.size() != 36 || exp.size() != obs.size()) begin
            n_bad++;
            $display("FAIL id_basic len got %0d want 36 (to=%0d)",
                     obs.size(), to);
        end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            n_total++;
            if (obs[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL id_basic beat %0d got %h want %h",
                         i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_id_rpath;
        bq_t req = '{8'h03, 8'h01, 8'hFE, 8'hFE, 8'hAA, 8'hBB};
        oq_t exp = model(req, 1'b0);
        oq_t obs;
        bit  to;
        rnd_rdy = 1'b0;
        run_pkt(req, 1'b0, exp.size(), obs, to);
        n_total++;
        if (to || obs.size() != 38) begin
            n_bad++;
            $display("FAIL id_rpath len got %0d want 38 (to=%0d)",
                     obs.size(), to);
        end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            n_total++;
            if (obs[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL id_rpath beat %0d got %h want %h",
                         i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_bad_type;
        bq_t req = '{8'h02, 8'hFE, 8'h10};
        oq_t obs;
        bit  to;
        rnd_rdy = 1'b0;
        run_pkt(req, 1'b0, 3, obs, to);
        n_total++;
        if (to || obs.size() != 3) begin
            n_bad++;
            $display("FAIL bad_type len got %0d want 3 (to=%0d)",
                     obs.size(), to);
        end else begin
            n_total++;
            if ({obs[0], obs[1], obs[2]} !== {10'h002, 10'h0FE, 10'h300}) begin
                n_bad++;
                $display("FAIL bad_type data got %h %h %h want 002 0fe 300",
                         obs[0], obs[1], obs[2]);
            end
        end
    endtask

    task automatic test_no_marker;
        bq_t req = '{8'h05, 8'h06};
        oq_t obs;
        bit  to;
        rnd_rdy = 1'b0;
        run_pkt(req, 1'b0, 2, obs, to);
        n_total++;
        if (to || obs.size() != 2) begin
            n_bad++;
            $display("FAIL no_marker len got %0d want 2 (to=%0d)",
                     obs.size(), to);
        end else begin
            n_total++;
            if ({obs[0], obs[1]} !== {10'h005, 10'h306}) begin
                n_bad++;
                $display("FAIL no_marker data got %h %h want 005 306",
                         obs[0], obs[1]);
            end
        end
    endtask

    task automatic test_backpressure;
        bq_t req = '{8'hFE, 8'hFE};
        oq_t exp = model(req, 1'b0);
        oq_t obs;
        bit  to;
        int  e0 = stab_err;
        rnd_rdy = 1'b1;
        run_pkt(req, 1'b0, exp.size(), obs, to);
        rnd_rdy = 1'b0;
        n_total++;
        if (to || obs.size() != exp.size()) begin
            n_bad++;
            $display("FAIL bp len got %0d want %0d (to=%0d)",
                     obs.size(), exp.size(), to);
        end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            n_total++;
            if (obs[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL bp beat %0d got %h want %h", i, obs[i], exp[i]);
            end
        end
        n_total++;
        if (stab_err - e0 != 0) begin
            n_bad++;
            $display("FAIL bp_stable got %0d violations want 0", stab_err - e0);
        end
    endtask

    task automatic test_reset_mid_send;
        bq_t req = '{8'hFE, 8'hFE};
        oq_t exp = model(req, 1'b0);
        oq_t obs;
        bit  to;
        int  w = 0;
        rnd_rdy = 1'b0;
        mon_q = {};
        send_bytes(req, 1'b0, to);
        while (mon_q.size() < 11 && w < 500) begin
            @(posedge clk);
            w++;
        end
        n_total++;
        if (to || w >= 500) begin
            n_bad++;
            $display("FAIL rst_mid reach got %0d beats want 11", mon_q.size());
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (out_tvalid !== 1'b0 || in_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid async got v=%b r=%b want 0 0",
                     out_tvalid, in_tready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_pkt(req, 1'b0, exp.size(), obs, to);
        n_total++;
        if (to || obs.size() != 36) begin
            n_bad++;
            $display("FAIL rst_mid len got %0d want 36 (to=%0d)",
                     obs.size(), to);
        end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            n_total++;
            if (obs[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL rst_mid beat %0d got %h want %h",
                         i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_random;
        for (int p = 0; p < 24; p++) begin
            bq_t  req;
            oq_t  exp;
            oq_t  obs;
            bit   to;
            logic b;
            int   kind = $urandom_range(0, 3);
            int   nr = $urandom_range(0, 3);
            for (int i = 0; i < nr; i++) req.push_back(8'($urandom_range(0, 253)));
            if (kind == 0) begin
                if (nr == 0) req.push_back(8'($urandom_range(0, 253)));
            end else begin
                req.push_back(8'hFE);
                req.push_back(kind == 3 ? 8'($urandom_range(0, 253)) : 8'hFE);
                for (int i = 0; i < $urandom_range(0, 3); i++)
                    req.push_back(8'($urandom_range(0, 255)));
            end
            b = ($urandom_range(0, 3) == 0);
            exp = model(req, b);
            rnd_rdy = 1'b1;
            run_pkt(req, b, exp.size(), obs, to);
            n_total++;
            if (to || obs.size() != exp.size()) begin
                n_bad++;
                $display("FAIL rand pkt %0d len got %0d want %0d (to=%0d)",
                         p, obs.size(), exp.size(), to);
            end
            for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
                n_total++;
                if (obs[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL rand pkt %0d beat %0d got %h want %h",
                             p, i, obs[i], exp[i]);
                end
            end
        end
        rnd_rdy = 1'b0;
    endtask

    initial begin
        test_reset;
        test_id_basic;
        test_id_rpath;
        test_bad_type;
        test_no_marker;
        test_backpressure;
        test_reset_mid_send;
        test_random;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
